imm_extend_stage: RTL and testbench
===================================

IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries; legal values are 2 to 8, power of two.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 flush  in  1  discards all buffered entries and any accept in the same cycle.
REQ-007 in_valid  in  1  Instr/ImmSrc/in_tag are valid.
REQ-008 in_ready  out  1  the block can accept this cycle.
REQ-009 Instr  in  32  raw RISC-V instruction word.
REQ-010 ImmSrc  in  3  immediate format select.
REQ-011 in_tag  in  TAG_W  opaque sideband, returned unchanged.
REQ-012 out_valid  out  1  ImmExt/out_tag/out_illegal are valid.
REQ-013 out_ready  in  1  consumer accepts this cycle.
REQ-014 ImmExt  out  XLEN  extended immediate.
REQ-015 out_tag  out  TAG_W  tag of the entry at the head.
REQ-016 out_illegal  out  1  head entry had ImmSrc=111.
REQ-017 illegal_cnt  out  8  saturating count of accepted illegal ImmSrc.

Function
REQ-018 Decode SHALL be: 000 I={sext Instr[31:20]}; 001 S={sext Instr[31:25],Instr[11:7]}; 010 B={sext Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}; 011 J={sext Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}.
REQ-019 Further decode: 100 U={sext Instr[31:12],12'b0}; sign extension applies above bit 31 when XLEN=64.
REQ-020 101 SHAMT SHALL zero-extend Instr[24:20] when XLEN=32 and Instr[25:20] when XLEN=64.
REQ-021 110 ZIMM SHALL zero-extend Instr[19:15], which is the CSR immediate.
REQ-022 111 SHALL produce ImmExt=0 and out_illegal=1; all other codes produce out_illegal=0.
REQ-023 An accept SHALL occur when in_valid && in_ready && !flush; the decoded result is written into the buffer tail on that edge.
REQ-024 Latency SHALL be exactly 1 cycle: an entry accepted at edge N is visible at the outputs after edge N.
REQ-025 There SHALL be no combinational path from the input ports to any output port.
REQ-026 The buffer SHALL be an in-order FIFO of DEPTH entries with a wrap-around read pointer, write pointer and occupancy count.
REQ-027 A pop SHALL occur when out_valid && out_ready.
REQ-028 in_ready SHALL equal (count<DEPTH) || out_ready.
REQ-029 When full with out_ready=1, a push and a pop SHALL both occur and count is unchanged.
REQ-030 A simultaneous push and pop SHALL leave count unchanged, including when count=1 and when the pointers wrap.
REQ-031 out_valid SHALL equal (count!=0).
REQ-032 When count=0, ImmExt, out_tag and out_illegal SHALL be 0.
REQ-033 Head outputs SHALL remain stable while out_valid && !out_ready.
REQ-034 flush=1 SHALL on that edge set count and both pointers to 0 and suppress any push or pop; illegal_cnt is not affected.
REQ-035 illegal_cnt SHALL increment on each accept with ImmSrc=111 and saturate at 255.

Reset
REQ-036 When reset=1 at an edge, count, pointers and illegal_cnt SHALL go to 0, so out_valid, ImmExt, out_tag and out_illegal are 0.
REQ-037 After reset, in_ready SHALL be 1 from the first cycle.
REQ-038 reset SHALL take priority over flush and over any push or pop.
REQ-039 A reset asserted mid-stream SHALL discard all buffered entries.

Verification
REQ-040 XLEN=32, single accepts, out_ready=1 -> outputs one cycle later:
- FEDCBA98/000 -> FFFFFFED
- 12345678/001 -> 0000012C
- 87654321/010 -> FFFFF066
- ABCDEF12/011 -> FFFDE2BC
- ABCDE123/100 -> ABCDE000
REQ-041 XLEN=64: ABCDE123/100 -> FFFFFFFFABCDE000; 02F00093/101 -> 000000000000002F; XLEN=32, 02F00093/101 -> 0000000F.
REQ-042 DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready=0 after 2 accepts; then out_ready=1 -> drains in order with tags intact, plus simultaneous push/pop at full.
REQ-043 Send 300 accepts with ImmSrc=111 -> each outputs ImmExt=0 and out_illegal=1; illegal_cnt saturates at 255.
REQ-044 Fill to 2 entries then assert flush together with in_valid -> next cycle out_valid=0 and count=0, the flush-cycle input is not captured, and illegal_cnt is unchanged.
REQ-045 reset asserted with 2 entries buffered and in_valid=1 -> next cycle all outputs are 0 and in_ready=1.

Source files
------------

// File: rtl/imm_extend_stage.sv
// Immediate extension stage: decodes a RISC-V immediate from the raw
// instruction word and buffers the result with its tag in a small FIFO.
// The decode is registered into the FIFO, so latency is exactly one cycle.
module imm_extend_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [7:0]       illegal_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  // Decode results
  logic [31:0]      imm32_c;
  logic             sext_c;
  logic             illegal_c;
  logic [5:0]       shamt_c;
  logic [XLEN-1:0]  imm_c;

  // FIFO storage and control
  logic [XLEN-1:0]  imm_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic             ill_mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [7:0]       ill_cnt_q, ill_cnt_d;

  logic             full_c;
  logic             push_c;
  logic             pop_c;

  // The opcode field never contributes to an immediate.
  logic             unused_opcode;
  assign unused_opcode = ^Instr[6:0];

  // Shift amount is 5 bits on RV32 and 6 bits on RV64.
  always_comb begin
    shamt_c = (XLEN == 64) ? Instr[25:20] : {1'b0, Instr[24:20]};
  end

  // Immediate decode into a 32-bit value plus a sign-extend flag.
  always_comb begin
    imm32_c   = '0;
    sext_c    = 1'b0;
    illegal_c = 1'b0;
    case (ImmSrc)
      SRC_I: begin
        imm32_c = {{20{Instr[31]}}, Instr[31:20]};
        sext_c  = 1'b1;
      end
      SRC_S: begin
        imm32_c = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
        sext_c  = 1'b1;
      end
      SRC_B: begin
        imm32_c = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
        sext_c  = 1'b1;
      end
      SRC_J: begin
        imm32_c = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
        sext_c  = 1'b1;
      end
      SRC_U: begin
        imm32_c = {Instr[31:12], 12'b0};
        sext_c  = 1'b1;
      end
      SRC_SHAMT: begin
        imm32_c = {26'b0, shamt_c};
      end
      SRC_ZIMM: begin
        imm32_c = {27'b0, Instr[19:15]};
      end
      default: begin
        imm32_c   = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

  // Widen to XLEN; sign extension only matters above bit 31 on RV64.
  always_comb begin
    if (sext_c) begin
      imm_c = XLEN'($signed(imm32_c));
    end else begin
      imm_c = XLEN'(imm32_c);
    end
  end

  // Handshake: a full buffer still accepts when the head leaves this cycle.
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    in_ready  = !full_c || out_ready;
    out_valid = (count_q != '0);
    push_c    = in_valid && in_ready && !flush;
    pop_c     = out_valid && out_ready && !flush;
  end

  // Next-state for pointers, occupancy and the illegal counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      end
      if (pop_c) begin
        rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      end
      case ({push_c, pop_c})
        2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
        2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
        default: count_d = count_q;
      endcase
    end

    if (push_c && illegal_c && (ill_cnt_q != 8'hFF)) begin
      ill_cnt_d = 8'(ill_cnt_q + 8'd1);
    end
  end

  // Control registers; reset wins over flush and over any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  // Payload storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      imm_mem_q[wr_ptr_q] <= imm_c;
      tag_mem_q[wr_ptr_q] <= in_tag;
      ill_mem_q[wr_ptr_q] <= illegal_c;
    end
  end

  // Head outputs read straight from storage, forced to zero when empty.
  always_comb begin
    ImmExt      = '0;
    out_tag     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      ImmExt      = imm_mem_q[rd_ptr_q];
      out_tag     = tag_mem_q[rd_ptr_q];
      out_illegal = ill_mem_q[rd_ptr_q];
    end
  end

  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: an RV32 and an RV64 instance share the same
// stimulus and are compared every cycle against a queue-based model.
module tb_imm_extend_stage;

  localparam int unsigned TW  = 5;
  localparam int unsigned DEP = 2;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [31:0]   instr;
  logic [2:0]    src;
  logic [TW-1:0] tag;

  logic          rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0]   imm32;
  logic [63:0]   imm64;
  logic [TW-1:0] tag32, tag64;
  logic [7:0]    cnt32, cnt64;

  always #5 clk = ~clk;

  imm_extend_stage #(.XLEN(32), .TAG_W(TW), .DEPTH(DEP)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .Instr(instr), .ImmSrc(src), .in_tag(tag), .out_valid(ov32), .out_ready(out_ready),
    .ImmExt(imm32), .out_tag(tag32), .out_illegal(ill32), .illegal_cnt(cnt32)
  );

  imm_extend_stage #(.XLEN(64), .TAG_W(TW), .DEPTH(DEP)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .Instr(instr), .ImmSrc(src), .in_tag(tag), .out_valid(ov64), .out_ready(out_ready),
    .ImmExt(imm64), .out_tag(tag64), .out_illegal(ill64), .illegal_cnt(cnt64)
  );

  typedef struct {
    logic [63:0]   i32;
    logic [63:0]   i64;
    logic [TW-1:0] tag;
    logic          ill;
  } ent_t;

  ent_t q[$];
  int   ill_model = 0;
  bit   known = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Immediate value from the ISA field definitions, using signed arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] s, input bit is64);
    longint ws;
    longint r;
    ws = longint'($signed(w));
    case (s)
      3'd0: r = ws >>> 20;
      3'd1: r = ((ws >>> 25) * 32) + longint'((w >> 7) & 32'h1F);
      3'd2: r = (w[31] ? -64'sd4096 : 64'sd0) + longint'((w >> 7) & 32'h1) * 2048
                + longint'((w >> 25) & 32'h3F) * 32 + longint'((w >> 8) & 32'hF) * 2;
      3'd3: r = (w[31] ? -64'sd1048576 : 64'sd0) + longint'((w >> 12) & 32'hFF) * 4096
                + longint'((w >> 20) & 32'h1) * 2048 + longint'((w >> 21) & 32'h3FF) * 2;
      3'd4: r = ws & -64'sd4096;
      3'd5: r = is64 ? longint'((w >> 20) & 32'h3F) : longint'((w >> 20) & 32'h1F);
      3'd6: r = longint'((w >> 15) & 32'h1F);
      default: r = 0;
    endcase
    if (is64) return 64'(r);
    return {32'h0, r[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: drive at negedge, compare outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input bit iv, input logic [31:0] w, input logic [2:0] s,
                      input logic [TW-1:0] t, input bit ordy, input bit fl, input bit rs);
    ent_t e;
    bit   pop, acc;
    @(negedge clk);
    in_valid  = iv;
    instr     = w;
    src       = s;
    tag       = t;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #1;
    if (known) begin
      e = '{i32: 64'h0, i64: 64'h0, tag: '0, ill: 1'b0};
      if (q.size() != 0) e = q[0];
      chk("out_valid32", 64'(ov32), 64'(q.size() != 0));
      chk("imm32", 64'(imm32), e.i32);
      chk("tag32", 64'(tag32), 64'(e.tag));
      chk("illegal32", 64'(ill32), 64'(e.ill));
      chk("ill_cnt32", 64'(cnt32), 64'(ill_model));
      chk("in_ready32", 64'(rdy32), 64'((q.size() < DEP) || ordy));
      chk("out_valid64", 64'(ov64), 64'(q.size() != 0));
      chk("imm64", imm64, e.i64);
      chk("tag64", 64'(tag64), 64'(e.tag));
      chk("illegal64", 64'(ill64), 64'(e.ill));
      chk("ill_cnt64", 64'(cnt64), 64'(ill_model));
    end
    @(posedge clk);
    cyc++;
    if (rs) begin
      q.delete();
      ill_model = 0;
      known = 1'b1;
    end else if (known) begin
      if (fl) begin
        q.delete();
      end else begin
        pop = (q.size() != 0) && ordy;
        acc = iv && ((q.size() < DEP) || ordy);
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.i32 = ref_imm(w, s, 1'b0);
          e.i64 = ref_imm(w, s, 1'b1);
          e.tag = t;
          e.ill = (s == 3'd7);
          q.push_back(e);
          if ((s == 3'd7) && (ill_model < 255)) ill_model++;
        end
      end
    end
  endtask

  logic [31:0] vw [5] = '{32'hFEDCBA98, 32'h12345678, 32'h87654321, 32'hABCDEF12, 32'hABCDE123};
  logic [2:0]  vs [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [31:0] ve [5] = '{32'hFFFFFFED, 32'h0000012C, 32'hFFFFF066, 32'hFFFDE2BC, 32'hABCDE000};

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; src = '0; tag = '0;

    // Power-on reset, then reset state with the consumer stalled.
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("rst_out_valid", 64'(ov32), 64'h0);
    chk("rst_in_ready", 64'(rdy32), 64'h1);
    chk("rst_ill_cnt", 64'(cnt32), 64'h0);

    // Known-answer decode vectors, one-cycle latency.
    for (int k = 0; k < 5; k++) begin
      step(1, vw[k], vs[k], TW'(k), 1, 0, 0);
      #2;
      chk("vec_rv32", 64'(imm32), {32'h0, ve[k]});
      chk("vec_tag", 64'(tag32), 64'(k));
    end
    #2;
    chk("vec_u_rv64", imm64, 64'hFFFFFFFFABCDE000);
    step(1, 32'h02F00093, 3'd5, 5, 1, 0, 0);
    #2;
    chk("shamt_rv64", imm64, 64'h000000000000002F);
    chk("shamt_rv32", 64'(imm32), 64'h000000000000000F);
    step(0, 0, 0, 0, 1, 0, 0);

    // Back-pressure: fill, blocked third push, push+pop at full, drain.
    step(1, 32'h00100093, 3'd0, 1, 0, 0, 0);
    step(1, 32'h00200093, 3'd0, 2, 0, 0, 0);
    #2;
    chk("full_in_ready", 64'(rdy32), 64'h0);
    step(1, 32'h00300093, 3'd0, 3, 0, 0, 0);
    step(1, 32'h00400093, 3'd0, 4, 1, 0, 0);
    #2;
    chk("full_pushpop_tag", 64'(tag32), 64'h2);
    step(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("drain_tag", 64'(tag32), 64'h4);
    chk("drain_imm", 64'(imm32), 64'h4);
    step(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("drained_valid", 64'(ov32), 64'h0);

    // Flush with a concurrent illegal input.
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 32'hFFFFFFFF, 3'd7, 7, 0, 0, 0);
    step(1, 32'h00500093, 3'd0, 8, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 3'd7, 9, 0, 1, 0);
    #2;
    chk("flush_valid", 64'(ov32), 64'h0);
    chk("flush_ill_cnt", 64'(cnt32), 64'h1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Reset mid-stream with entries buffered and input offered.
    step(1, 32'h00600093, 3'd0, 10, 0, 0, 0);
    step(1, 32'h00700093, 3'd0, 11, 0, 0, 0);
    step(1, 32'h00800093, 3'd7, 12, 0, 0, 1);
    #2;
    chk("rst_mid_valid", 64'(ov32), 64'h0);
    chk("rst_mid_imm", 64'(imm32), 64'h0);
    chk("rst_mid_tag", 64'(tag32), 64'h0);
    chk("rst_mid_ill_cnt", 64'(cnt32), 64'h0);
    chk("rst_mid_in_ready", 64'(rdy32), 64'h1);

    // Illegal counter saturation.
    for (int k = 0; k < 300; k++) step(1, $urandom, 3'd7, TW'($urandom), 1, 0, 0);
    #2;
    chk("sat_ill_cnt", 64'(cnt64), 64'd255);
    chk("sat_imm", 64'(imm32), 64'h0);
    chk("sat_illegal", 64'(ill32), 64'h1);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), TW'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end
    step(0, 0, 0, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
